// File: rtl/pb_pkg.sv
// Shared constants and encodings for the multi-channel push-button debounce/counter block.
// Holds default timings, count-direction encodings and the per-channel counter operation type.
package pb_pkg;

    // Default debounce window: 1 ms at 50 MHz.
    localparam int unsigned DEF_STABLE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_CYCLES = 0;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_CLR  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/pb_debounce_ch.sv
// One push-button channel: 2-FF synchronizer, debounce timer, registered edge pulses and
// an optional hold-to-auto-repeat timer. The step output marks every cycle a count should occur.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int unsigned DB_W          = 16,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned RPT_W         = 24,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic state,
    output logic down,
    output logic up,
    output logic step
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);

    logic            pressed_raw;
    logic            sync1_reg;
    logic            sync2_reg;
    logic [DB_W-1:0] db_timer_reg;
    logic [DB_W-1:0] db_timer_next;
    logic            state_reg;
    logic            state_next;
    logic            down_reg;
    logic            down_next;
    logic            up_reg;
    logic            up_next;
    logic            flip;
    logic            rpt_tick;

    assign pressed_raw = ACTIVE_LOW ? ~pb : pb;

    // Any disagreement restarts nothing; only an unbroken run of disagreement flips the state.
    always_comb begin
        db_timer_next = '0;
        state_next    = state_reg;
        flip          = 1'b0;
        if (sync2_reg != state_reg) begin
            if (db_timer_reg == DB_LAST) begin
                flip       = 1'b1;
                state_next = ~state_reg;
            end else begin
                db_timer_next = db_timer_reg + DB_W'(1);
            end
        end
    end

    always_comb begin
        down_next = flip & ~state_reg;
        up_next   = flip & state_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            db_timer_reg <= '0;
            state_reg    <= 1'b0;
            down_reg     <= 1'b0;
            up_reg       <= 1'b0;
        end else begin
            sync1_reg    <= pressed_raw;
            sync2_reg    <= sync1_reg;
            db_timer_reg <= db_timer_next;
            state_reg    <= state_next;
            down_reg     <= down_next;
            up_reg       <= up_next;
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_rpt
            localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

            logic [RPT_W-1:0] rpt_timer_reg;
            logic [RPT_W-1:0] rpt_timer_next;

            // Cleared in the press cycle so repeats land exactly REPEAT_CYCLES apart from it.
            always_comb begin
                rpt_timer_next = '0;
                if (state_reg && !down_reg && (rpt_timer_reg != RPT_LAST)) begin
                    rpt_timer_next = rpt_timer_reg + RPT_W'(1);
                end
            end

            assign rpt_tick = state_reg & ~down_reg & (rpt_timer_reg == RPT_LAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rpt_timer_reg <= '0;
                end else begin
                    rpt_timer_reg <= rpt_timer_next;
                end
            end
        end else begin : g_no_rpt
            assign rpt_tick = 1'b0;
        end
    endgenerate

    assign state = state_reg;
    assign down  = down_reg;
    assign up    = up_reg;
    assign step  = down_reg | rpt_tick;

endmodule

// File: rtl/pb_debounce_counter_multi.sv
// NCH independent debounced push buttons, each driving an up/down press counter with
// clear priority and selectable wrap or saturate behaviour.
module pb_debounce_counter_multi
    import pb_pkg::*;
#(
    parameter int unsigned NCH           = 4,
    parameter int unsigned Y_W           = 8,
    parameter int unsigned DB_W          = 16,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned RPT_W         = 24,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned SATURATE      = 0,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     pb,
    input  logic [NCH-1:0]     mode,
    input  logic [NCH-1:0]     clr,
    output logic [NCH-1:0]     pb_state,
    output logic [NCH-1:0]     pb_down,
    output logic [NCH-1:0]     pb_up,
    output logic [NCH*Y_W-1:0] Y
);

    localparam bit             SAT_EN = (SATURATE != 0);
    localparam logic [Y_W-1:0] Y_MAX  = '1;
    localparam logic [Y_W-1:0] Y_MIN  = '0;

    logic [NCH-1:0] step;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            cnt_op_e        op;
            logic [Y_W-1:0] cnt_reg;
            logic [Y_W-1:0] cnt_next;

            pb_debounce_ch #(
                .DB_W          (DB_W),
                .STABLE_CYCLES (STABLE_CYCLES),
                .RPT_W         (RPT_W),
                .REPEAT_CYCLES (REPEAT_CYCLES),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .pb    (pb[gi]),
                .state (pb_state[gi]),
                .down  (pb_down[gi]),
                .up    (pb_up[gi]),
                .step  (step[gi])
            );

            // Clear wins over a coincident step, which is simply lost.
            always_comb begin
                op = OP_HOLD;
                if (clr[gi]) begin
                    op = OP_CLR;
                end else if (step[gi]) begin
                    op = (mode[gi] == MODE_DOWN) ? OP_DEC : OP_INC;
                end
            end

            always_comb begin
                cnt_next = cnt_reg;
                unique case (op)
                    OP_CLR:  cnt_next = '0;
                    OP_INC:  cnt_next = (SAT_EN && (cnt_reg == Y_MAX)) ? cnt_reg
                                                                        : cnt_reg + Y_W'(1);
                    OP_DEC:  cnt_next = (SAT_EN && (cnt_reg == Y_MIN)) ? cnt_reg
                                                                        : cnt_reg - Y_W'(1);
                    default: cnt_next = cnt_reg;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign Y[gi*Y_W +: Y_W] = cnt_reg;
        end
    endgenerate

endmodule
